xgmii_link_fault_monitor: RTL
=============================

# xgmii_link_fault_monitor

Clause 46 reconciliation-sublayer link-fault monitor on the 64-bit XGMII, between `sfp_ethernet_phy_control` and `xgmii_fpga_core` in the 156.25 MHz `xgmii_clock` domain. It watches RX for local/remote fault sequence ordered sets, qualifies them with the standard 4-sequence/128-column rule, and reports link state. While a fault is active, it overrides TX (local fault → send remote fault, remote fault → send idle) and blanks RX toward the core.

## Interface
- `SEQ_THRESHOLD`, 4, number of same-type fault sequences needed to declare a fault (range 2..7).
- `COL_WINDOW`, 128, number of non-sequence columns that clear fault/sequence state (power of two, ≥ 8).
- `i_clock`  in  1  XGMII clock, 156.25 MHz; the only clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_phy_rx_data` / `i_phy_rx_control`  in  64 / 8  RX XGMII from PHY; lane k = bits [8k+7:8k], ctrl bit k.
- `o_core_rx_data` / `o_core_rx_control`  out  64 / 8  RX XGMII to core.
- `i_core_tx_data` / `i_core_tx_control`  in  64 / 8  TX XGMII from core.
- `o_phy_tx_data` / `o_phy_tx_control`  out  64 / 8  TX XGMII to PHY.
- `o_link_fault`  out  2  link_fault_t: 0 OK, 1 LOCAL, 2 REMOTE.
- `o_link_up`  out  1  high when `o_link_fault` == OK.
- `o_local_fault_count`, `o_remote_fault_count`  out  16 each  fault-entry counters (see Configuration).

## Operation
- Column A = lanes 0-3; column B = lanes 4-7. Each cycle, A is processed and then B, sequentially (B sees A's updated state).
- A column is a fault sequence only if: lane0 = 0x9C with ctrl=1; lanes1-3 ctrl=0; lanes1,2 = 0x00; lane3 = 0x01 (LOCAL) or 0x02 (REMOTE). Any other column, including a 0x9C column with another lane3 value, is an ordinary column.
- State: `last_seq` (NONE/LOCAL/REMOTE), `seq_cnt` (0..SEQ_THRESHOLD, saturating), `col_cnt` (0..COL_WINDOW, saturating), `fault`.
- Fault-sequence column of type T:
  - Clear `col_cnt`.
  - If T == `last_seq`, increment `seq_cnt`; otherwise set `last_seq` = T and `seq_cnt` = 1.
  - When `seq_cnt` reaches SEQ_THRESHOLD, set `fault` = T.
  - A type change does not alter `fault`.
- Ordinary column: increment `col_cnt`. When it reaches COL_WINDOW, set `fault` = OK, `seq_cnt` = 0, `last_seq` = NONE.
- RX: the registered copy of the input word goes to the core. It is forced to all-idle (data 0x0707070707070707, ctrl 0xFF) when the fault state after processing that word is not OK.
- TX, using the fault state registered at the start of the cycle:
  - LOCAL → data 0x0200009C_0200009C, ctrl 0x11 (remote fault in both columns).
  - REMOTE → all-idle.
  - OK → pass-through, subject to `tx_hold`.
- `tx_hold` is set whenever an override is emitted. While `tx_hold` is set and fault is OK, all-idle is emitted until an input TX word is exactly all-idle. That word clears `tx_hold` and is itself passed through. This prevents forwarding a frame tail.
- Entering an override mid-frame truncates the frame. This is accepted behaviour.

## Timing
- RX and TX latency: 1 cycle, registered outputs.
- `o_link_fault` / `o_link_up` update in the same cycle the corresponding RX word appears on `o_core_rx_*`.
- A TX override takes effect on the word output one cycle after `o_link_fault` changes.
- Reset values:
  - `o_core_rx_*` and `o_phy_tx_*`: all-idle.
  - `o_link_fault` = OK, `o_link_up` = 1, counters = 0.
  - Internal: `last_seq` = NONE, counts 0, `tx_hold` = 0.
- Reset asserted mid-fault or mid-frame returns to the reset values on the next edge. No partial state is retained.
- Two same-type sequences in one word count as 2.
- A LOCAL in A followed by a REMOTE in B leaves `last_seq` = REMOTE, `seq_cnt` = 1.

## Configuration
- `XGMII_LINK_FAULT_STATS_EN` defined:
  - `o_local_fault_count` / `o_remote_fault_count` increment by 1 on each transition of `fault` into LOCAL / REMOTE.
  - 16-bit, saturating at 0xFFFF.
  - Updated in the same cycle as `o_link_fault`.
- Not defined: both outputs are constant 0 and no counter flops exist.

## Structure
- Shared package `xgmii_pkg`:
  - `link_fault_t` enum.
  - `XGMII_IDLE_DATA`, `XGMII_IDLE_CTRL`, `XGMII_SEQ_CHAR` (0x9C).
  - `XGMII_LF_CODE` (0x01), `XGMII_RF_CODE` (0x02).
  - `XGMII_RF_WORD_DATA` / `XGMII_RF_WORD_CTRL`.
- Sub-module `xgmii_seq_column_decode`: combinational classifier taking a 32-bit column and 4 control bits, returning NONE/LOCAL/REMOTE. Instantiated twice.

## Test plan
- Reset, then idle stimulus → outputs all-idle, `o_link_fault` = 0, `o_link_up` = 1.
- Four words with a LOCAL sequence in lane0 only → `o_link_fault` = 1 in the cycle the 4th word exits. The next TX output is 0x0200009C0200009C/0x11, and RX to the core is idle. With the macro defined, `o_local_fault_count` = 1.
- Three REMOTE sequences, then 64 idle words → `o_link_fault` stays 0 throughout and TX passes through.
- REMOTE fault established, then exactly 64 idle words (128 columns) → `o_link_fault` returns to 0 on the 64th word. At 63 words it is still 2.
- LOCAL fault clears while the core drives mid-frame data (ctrl 0x00) → TX stays all-idle. The first all-idle core word and all later words pass through unchanged.
- Two words, each with LOCAL in both lane0 and lane4 → fault declared on the 2nd word. With the macro undefined, the counters read 0.

Source files
------------

// File: rtl/xgmii_pkg.sv
// Shared XGMII definitions: link fault encoding, idle and fault ordered-set
// constants, and the column classification type.
package xgmii_pkg;

  // Reported link state
  typedef enum logic [1:0] {
    LINK_OK     = 2'd0,
    LINK_LOCAL  = 2'd1,
    LINK_REMOTE = 2'd2
  } link_fault_t;

  // Classification of one 32-bit XGMII column
  typedef enum logic [1:0] {
    SEQ_NONE   = 2'd0,
    SEQ_LOCAL  = 2'd1,
    SEQ_REMOTE = 2'd2
  } seq_type_t;

  localparam logic [63:0] XGMII_IDLE_DATA    = 64'h0707070707070707;
  localparam logic [7:0]  XGMII_IDLE_CTRL    = 8'hFF;
  localparam logic [7:0]  XGMII_SEQ_CHAR     = 8'h9C;
  localparam logic [7:0]  XGMII_LF_CODE      = 8'h01;
  localparam logic [7:0]  XGMII_RF_CODE      = 8'h02;
  localparam logic [63:0] XGMII_RF_WORD_DATA = 64'h0200009C_0200009C;
  localparam logic [7:0]  XGMII_RF_WORD_CTRL = 8'h11;

  // Fault state that a qualified run of the given sequence type declares
  function automatic link_fault_t seq_to_fault(input seq_type_t s);
    case (s)
      SEQ_LOCAL:  return LINK_LOCAL;
      SEQ_REMOTE: return LINK_REMOTE;
      default:    return LINK_OK;
    endcase
  endfunction

endpackage

// File: rtl/xgmii_seq_column_decode.sv
// Combinational classifier for one XGMII column: reports whether the four
// lanes form a local or remote fault sequence ordered set.
module xgmii_seq_column_decode
  import xgmii_pkg::*;
(
  input  logic [31:0] column_data,
  input  logic [3:0]  column_ctrl,
  output seq_type_t   seq_type
);

  logic is_seq_frame;

  assign is_seq_frame = (column_ctrl == 4'b0001) &&
                        (column_data[7:0] == XGMII_SEQ_CHAR) &&
                        (column_data[23:8] == 16'h0000);

  // Only the two fault codes in lane 3 qualify; any other sequence code is an ordinary column
  always_comb begin
    seq_type = SEQ_NONE;
    if (is_seq_frame) begin
      if (column_data[31:24] == XGMII_LF_CODE) begin
        seq_type = SEQ_LOCAL;
      end else if (column_data[31:24] == XGMII_RF_CODE) begin
        seq_type = SEQ_REMOTE;
      end
    end
  end

endmodule

// File: rtl/xgmii_link_fault_monitor.sv
// Reconciliation-sublayer link fault monitor on a 64-bit XGMII.
// Qualifies fault sequences on RX, blanks RX toward the core while faulted,
// and overrides TX toward the PHY (local -> remote fault, remote -> idle).
// Optional fault-entry counters are built when XGMII_LINK_FAULT_STATS_EN is defined.
module xgmii_link_fault_monitor
  import xgmii_pkg::*;
#(
  parameter int SEQ_THRESHOLD = 4,
  parameter int COL_WINDOW    = 128
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [63:0] i_phy_rx_data,
  input  logic [7:0]  i_phy_rx_control,
  output logic [63:0] o_core_rx_data,
  output logic [7:0]  o_core_rx_control,
  input  logic [63:0] i_core_tx_data,
  input  logic [7:0]  i_core_tx_control,
  output logic [63:0] o_phy_tx_data,
  output logic [7:0]  o_phy_tx_control,
  output link_fault_t o_link_fault,
  output logic        o_link_up,
  output logic [15:0] o_local_fault_count,
  output logic [15:0] o_remote_fault_count
);

  localparam int SEQ_W = $clog2(SEQ_THRESHOLD + 1);
  localparam int COL_W = $clog2(COL_WINDOW + 1);
  localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(SEQ_THRESHOLD);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_WINDOW);

  seq_type_t        col_type_a;
  seq_type_t        col_type_b;
  seq_type_t        last_seq;
  seq_type_t        last_seq_next;
  logic [SEQ_W-1:0] seq_cnt;
  logic [SEQ_W-1:0] seq_cnt_next;
  logic [COL_W-1:0] col_cnt;
  logic [COL_W-1:0] col_cnt_next;
  link_fault_t      fault;
  link_fault_t      fault_next;
  logic             tx_hold;
  logic             tx_in_idle;

  xgmii_seq_column_decode u_decode_a (
    .column_data (i_phy_rx_data[31:0]),
    .column_ctrl (i_phy_rx_control[3:0]),
    .seq_type    (col_type_a)
  );

  xgmii_seq_column_decode u_decode_b (
    .column_data (i_phy_rx_data[63:32]),
    .column_ctrl (i_phy_rx_control[7:4]),
    .seq_type    (col_type_b)
  );

  assign tx_in_idle   = (i_core_tx_data == XGMII_IDLE_DATA) &&
                        (i_core_tx_control == XGMII_IDLE_CTRL);
  assign o_link_fault = fault;
  assign o_link_up    = (fault == LINK_OK);

  // Walk column A then column B so that B is judged against A's updated state
  always_comb begin
    seq_type_t cur;
    last_seq_next = last_seq;
    seq_cnt_next  = seq_cnt;
    col_cnt_next  = col_cnt;
    fault_next    = fault;
    cur           = SEQ_NONE;
    for (int c = 0; c < 2; c++) begin
      cur = (c == 0) ? col_type_a : col_type_b;
      if (cur != SEQ_NONE) begin
        col_cnt_next = '0;
        if (cur == last_seq_next) begin
          if (seq_cnt_next != SEQ_MAX) begin
            seq_cnt_next = seq_cnt_next + SEQ_W'(1);
          end
        end else begin
          last_seq_next = cur;
          seq_cnt_next  = SEQ_W'(1);
        end
        if (seq_cnt_next == SEQ_MAX) begin
          fault_next = seq_to_fault(cur);
        end
      end else begin
        if (col_cnt_next != COL_MAX) begin
          col_cnt_next = col_cnt_next + COL_W'(1);
        end
        if (col_cnt_next == COL_MAX) begin
          fault_next    = LINK_OK;
          seq_cnt_next  = '0;
          last_seq_next = SEQ_NONE;
        end
      end
    end
  end

  // Register fault tracking state and the RX word, blanked when the post-word state is faulted
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_seq          <= SEQ_NONE;
      seq_cnt           <= '0;
      col_cnt           <= '0;
      fault             <= LINK_OK;
      o_core_rx_data    <= XGMII_IDLE_DATA;
      o_core_rx_control <= XGMII_IDLE_CTRL;
    end else begin
      last_seq <= last_seq_next;
      seq_cnt  <= seq_cnt_next;
      col_cnt  <= col_cnt_next;
      fault    <= fault_next;
      if (fault_next != LINK_OK) begin
        o_core_rx_data    <= XGMII_IDLE_DATA;
        o_core_rx_control <= XGMII_IDLE_CTRL;
      end else begin
        o_core_rx_data    <= i_phy_rx_data;
        o_core_rx_control <= i_phy_rx_control;
      end
    end
  end

  // TX override from the current fault state; after an override, hold idle until the core itself sends idle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_phy_tx_data    <= XGMII_IDLE_DATA;
      o_phy_tx_control <= XGMII_IDLE_CTRL;
      tx_hold          <= 1'b0;
    end else begin
      case (fault)
        LINK_LOCAL: begin
          o_phy_tx_data    <= XGMII_RF_WORD_DATA;
          o_phy_tx_control <= XGMII_RF_WORD_CTRL;
          tx_hold          <= 1'b1;
        end
        LINK_REMOTE: begin
          o_phy_tx_data    <= XGMII_IDLE_DATA;
          o_phy_tx_control <= XGMII_IDLE_CTRL;
          tx_hold          <= 1'b1;
        end
        default: begin
          if (tx_hold && !tx_in_idle) begin
            o_phy_tx_data    <= XGMII_IDLE_DATA;
            o_phy_tx_control <= XGMII_IDLE_CTRL;
          end else begin
            o_phy_tx_data    <= i_core_tx_data;
            o_phy_tx_control <= i_core_tx_control;
            tx_hold          <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef XGMII_LINK_FAULT_STATS_EN
  logic [15:0] local_count;
  logic [15:0] remote_count;

  // Count entries into each fault state, saturating rather than wrapping
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      local_count  <= '0;
      remote_count <= '0;
    end else begin
      if ((fault_next == LINK_LOCAL) && (fault != LINK_LOCAL) && (local_count != 16'hFFFF)) begin
        local_count <= local_count + 16'd1;
      end
      if ((fault_next == LINK_REMOTE) && (fault != LINK_REMOTE) && (remote_count != 16'hFFFF)) begin
        remote_count <= remote_count + 16'd1;
      end
    end
  end

  assign o_local_fault_count  = local_count;
  assign o_remote_fault_count = remote_count;
`else
  assign o_local_fault_count  = 16'h0000;
  assign o_remote_fault_count = 16'h0000;
`endif

endmodule
